// File: rtl/wb_port_arbiter_pkg.sv
// ============================================================================
// Module      : wb_port_arbiter_pkg
// Description : Shared widths and grant encoding for the writeback port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_port_arbiter_pkg;

  localparam int C_XLEN = 32;
  localparam int C_AW   = 5;
  localparam int C_CNTW = 16;

  typedef enum logic {
    SRC_EX  = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

endpackage

`default_nettype wire

// File: rtl/wb_port_arbiter_rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter; req[0]=EX, req[1]=MEM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import wb_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic [1:0] o_gnt
);

  src_e r_last;
  src_e w_last_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= SRC_MEM;
    end else begin
      r_last <= w_last_nxt;
    end
  end

  // On a tie the source that did not win last time is served.
  always_comb begin
    o_gnt      = i_req;
    w_last_nxt = r_last;
    if (i_req == 2'b11) begin
      o_gnt = (r_last == SRC_MEM) ? 2'b01 : 2'b10;
    end
    if (i_update) begin
      w_last_nxt = o_gnt[1] ? SRC_MEM : SRC_EX;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the register-file write port between EX and MEM sources.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int XLEN = C_XLEN,
  parameter int AW   = C_AW,
  parameter int CNTW = C_CNTW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_ex_valid,
  input  logic [AW-1:0]   i_ex_rd,
  input  logic [XLEN-1:0] i_ex_data,
  output logic            o_ex_ready,
  input  logic            i_mem_valid,
  input  logic [AW-1:0]   i_mem_rd,
  input  logic [XLEN-1:0] i_mem_data,
  output logic            o_mem_ready,
  output logic            o_regwr,
  output logic [AW-1:0]   o_rdaddr,
  output logic [XLEN-1:0] o_win,
  output logic [CNTW-1:0] o_conflict_cnt
);

  logic [1:0]      w_gnt;
  logic            w_xfer;
  logic [AW-1:0]   w_sel_rd;
  logic [XLEN-1:0] w_sel_data;
  logic            w_conflict;

  logic            r_regwr;
  logic [AW-1:0]   r_rdaddr;
  logic [XLEN-1:0] r_win;
  logic [CNTW-1:0] r_conflict_cnt;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .i_req    ({i_mem_valid, i_ex_valid}),
    .i_update (w_xfer),
    .o_gnt    (w_gnt)
  );

  assign o_ex_ready  = w_gnt[0];
  assign o_mem_ready = w_gnt[1];
  assign w_xfer      = |w_gnt;
  assign w_sel_rd    = w_gnt[1] ? i_mem_rd   : i_ex_rd;
  assign w_sel_data  = w_gnt[1] ? i_mem_data : i_ex_data;
  assign w_conflict  = i_ex_valid & i_mem_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_regwr        <= 1'b0;
      r_rdaddr       <= '0;
      r_win          <= '0;
      r_conflict_cnt <= '0;
    end else begin
      // x0 writes complete the handshake but never reach the register file.
      r_regwr <= w_xfer && (w_sel_rd != '0);
      if (w_xfer) begin
        r_rdaddr <= w_sel_rd;
        r_win    <= w_sel_data;
      end
      if (w_conflict && !(&r_conflict_cnt)) begin
        r_conflict_cnt <= r_conflict_cnt + 1'b1;
      end
    end
  end

  assign o_regwr        = r_regwr;
  assign o_rdaddr       = r_rdaddr;
  assign o_win          = r_win;
  assign o_conflict_cnt = r_conflict_cnt;

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Directed and random checks of wb_port_arbiter against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_port_arbiter;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            ex_valid, mem_valid;
  logic [AW-1:0]   ex_rd, mem_rd;
  logic [XLEN-1:0] ex_data, mem_data;
  logic            ex_ready, mem_ready;
  logic            regwr;
  logic [AW-1:0]   rdaddr;
  logic [XLEN-1:0] win;
  logic [CNTW-1:0] conflict_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state: who won the last transfer (0=EX, 1=MEM) and expected outputs.
  int              m_last;
  logic            m_regwr;
  logic [AW-1:0]   m_rdaddr;
  logic [XLEN-1:0] m_win;
  int              m_cnt;

  wb_port_arbiter #(.XLEN(XLEN), .AW(AW), .CNTW(CNTW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_ex_valid     (ex_valid),
    .i_ex_rd        (ex_rd),
    .i_ex_data      (ex_data),
    .o_ex_ready     (ex_ready),
    .i_mem_valid    (mem_valid),
    .i_mem_rd       (mem_rd),
    .i_mem_data     (mem_data),
    .o_mem_ready    (mem_ready),
    .o_regwr        (regwr),
    .o_rdaddr       (rdaddr),
    .o_win          (win),
    .o_conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_last   = 1;
    m_regwr  = 1'b0;
    m_rdaddr = '0;
    m_win    = '0;
    m_cnt    = 0;
  endtask

  // One clock: drive inputs, check readies, clock, update model, check registered outputs.
  task automatic cycle(input bit r,
                       input bit ev, input logic [AW-1:0] erd, input logic [XLEN-1:0] ed,
                       input bit mv, input logic [AW-1:0] mrd, input logic [XLEN-1:0] md,
                       output bit eg, output bit mg);
    rst = r;
    ex_valid = ev;  ex_rd = erd;  ex_data = ed;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    #1;
    if (ev && mv) begin
      eg = (m_last == 1);
      mg = !eg;
    end else begin
      eg = ev;
      mg = mv;
    end
    check("ex_ready", ex_ready, eg);
    check("mem_ready", mem_ready, mg);
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      if (eg || mg) begin
        m_regwr  = eg ? (erd != 0) : (mrd != 0);
        m_rdaddr = eg ? erd : mrd;
        m_win    = eg ? ed : md;
        m_last   = eg ? 0 : 1;
      end else begin
        m_regwr = 1'b0;
      end
      if (ev && mv) m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
    end
    check("regwr", regwr, m_regwr);
    if (m_regwr) begin
      check("rdaddr", rdaddr, m_rdaddr);
      check("win", win, m_win);
    end
    check("conflict_cnt", conflict_cnt, m_cnt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ex_valid = 1'b0; mem_valid = 1'b0;
    ex_rd = '0; mem_rd = '0; ex_data = '0; mem_data = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  initial begin
    bit eg, mg;
    bit pe, pm;
    logic [AW-1:0] prd_e, prd_m;
    logic [XLEN-1:0] pd_e, pd_m;
    logic [1:0] seq;

    do_reset();
    check("rst_regwr", regwr, 1'b0);
    check("rst_rdaddr", rdaddr, '0);
    check("rst_win", win, '0);
    check("rst_cnt", conflict_cnt, '0);

    // Single EX write, then idle.
    cycle(0, 1, 5'd5, 32'hDEADBEEF, 0, '0, '0, eg, mg);
    check("single_rdaddr", rdaddr, 5'd5);
    check("single_win", win, 32'hDEADBEEF);
    cycle(0, 0, '0, '0, 0, '0, '0, eg, mg);
    check("single_idle_regwr", regwr, 1'b0);

    // Tie from reset: EX first, then MEM.
    do_reset();
    cycle(0, 1, 5'd3, 32'h33, 1, 5'd7, 32'h77, eg, mg);
    check("tie_first_ex", {eg, mg}, 2'b10);
    cycle(0, 0, 5'd3, 32'h33, 1, 5'd7, 32'h77, eg, mg);
    check("tie_second_rdaddr", rdaddr, 5'd7);
    check("tie_cnt", conflict_cnt, 4'd1);

    // Continuous ties alternate.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 5'd1 + 5'(i), $urandom, 1, 5'd10 + 5'(i), $urandom, eg, mg);
      seq = {eg, mg};
      check("alt_grant", seq, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    check("alt_cnt", conflict_cnt, 4'd6);

    // x0 from MEM: accepted, no write, pointer moves so next tie goes to EX.
    cycle(0, 0, '0, '0, 1, 5'd0, 32'h1234, eg, mg);
    check("x0_regwr", regwr, 1'b0);
    cycle(0, 1, 5'd9, 32'h99, 1, 5'd11, 32'hBB, eg, mg);
    check("x0_next_tie_ex", {eg, mg}, 2'b10);

    // Random traffic under the source hold rule.
    do_reset();
    pe = 0; pm = 0;
    prd_e = '0; prd_m = '0; pd_e = '0; pd_m = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pe && ($urandom_range(9) < 6)) begin
        pe = 1; prd_e = AW'($urandom); pd_e = $urandom;
      end
      if (!pm && ($urandom_range(9) < 6)) begin
        pm = 1; prd_m = AW'($urandom); pd_m = $urandom;
      end
      cycle(0, pe, prd_e, pd_e, pm, prd_m, pd_m, eg, mg);
      if (eg) pe = 0;
      if (mg) pm = 0;
    end

    // Saturation, then reset during an accepted write.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, AW'($urandom), $urandom, 1, AW'($urandom), $urandom, eg, mg);
    end
    check("sat_cnt", conflict_cnt, 4'd15);
    cycle(1, 1, 5'd4, 32'hCAFE0004, 0, '0, '0, eg, mg);
    check("rst_write_regwr", regwr, 1'b0);
    check("rst_write_cnt", conflict_cnt, 4'd0);
    cycle(0, 1, 5'd6, 32'h66, 1, 5'd8, 32'h88, eg, mg);
    check("post_rst_tie_ex", {eg, mg}, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
